key_debounce: RTL
=================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter N_KEYS, default 4, number of independent key channels.
REQ-002 Parameter DEB_CYCLES, default 1_000_000 (20 ms at 50 MHz), consecutive stable cycles required to accept a level change; legal range 2..2^24.
REQ-003 CLK  in  1  single system clock; all state SHALL update on its rising edge only.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 KEY_SW  in  N_KEYS  raw asynchronous keys, active-low (0 = pressed).
REQ-006 key  out  N_KEYS  debounced key level, active-high (1 = pressed).
REQ-007 key_press  out  N_KEYS  one-cycle pulse on an accepted press.
REQ-008 key_release  out  N_KEYS  one-cycle pulse on an accepted release.

Function
REQ-009 Each KEY_SW bit SHALL pass through its own 2-flop synchronizer before any other logic uses it; no combinational path from KEY_SW to any output.
REQ-010 Each channel SHALL run an independent FSM with states IDLE, PRESS_CHK, PRESSED, REL_CHK and its own stability counter, width $clog2(DEB_CYCLES+1).
REQ-011 IDLE: synchronized level pressed -> PRESS_CHK, counter = 1; otherwise stay, counter = 0.
REQ-012 PRESS_CHK: level released -> IDLE, counter = 0 (glitch rejected, no pulse); level pressed and counter = DEB_CYCLES-1 -> PRESSED; otherwise counter +1.
REQ-013 PRESSED: level released -> REL_CHK, counter = 1; otherwise stay.
REQ-014 REL_CHK: level pressed -> PRESSED, counter = 0 (no pulse); level released and counter = DEB_CYCLES-1 -> IDLE; otherwise counter +1.
REQ-015 key SHALL be 1 exactly in PRESSED and REL_CHK, registered.
REQ-016 key_press SHALL be high for exactly the one cycle following the PRESS_CHK->PRESSED transition; key_release likewise for REL_CHK->IDLE.
REQ-017 Latency: a KEY_SW change held stable from clock edge E SHALL produce the key change and pulse visible after edge E+1+DEB_CYCLES; fixed, no jitter.
REQ-018 A bounce lasting < DEB_CYCLES cycles SHALL produce no change on key and no pulse.
REQ-019 key_press and key_release of the same channel SHALL never be high in the same cycle; a channel SHALL never emit two consecutive press pulses without an intervening release pulse.
REQ-020 Channels SHALL be fully independent; simultaneous changes on several keys SHALL produce pulses in the same cycle on each.
REQ-021 Counter SHALL never exceed DEB_CYCLES-1; no wrap-around for a key held indefinitely.

Reset
REQ-022 RESET high at an edge SHALL force: all FSMs IDLE, counters 0, synchronizer flops to 1 (released), key = 0, key_press = 0, key_release = 0.
REQ-023 Reset asserted mid-PRESS_CHK or mid-PRESSED SHALL discard progress without emitting any pulse; a key held through reset release SHALL be accepted as a fresh press after the full REQ-017 latency.
REQ-024 RESET SHALL take priority over all other inputs in the same cycle.

Structure
REQ-025 Package key_debounce_pkg SHALL hold the FSM state enum (deb_state_t) and the DEB_CYCLES default constant.
REQ-026 One sub-module key_debounce_ch (synchronizer + FSM + counter for one key) SHALL be instantiated N_KEYS times via generate.
REQ-027 Outputs feed the trigger-demo stage directly; no further inversion needed downstream.

Verification (DEB_CYCLES = 4)
REQ-028 KEY_SW[0] driven 0 at edge 10, held -> key[0] rises and key_press[0] high for one cycle after edge 15; other bits stay 0.
REQ-029 KEY_SW[1] toggles 0/1 every 2 cycles for 20 cycles, then 1 -> key[1], key_press[1], key_release[1] stay 0 throughout.
REQ-030 Held press on key 2 then KEY_SW[2]=1 at edge 40 -> key[2] falls and key_release[2] pulses after edge 45; exactly one press and one release pulse total.
REQ-031 KEY_SW = 4'b0000 at edge 10 -> all four key_press bits pulse in the same cycle after edge 15.
REQ-032 KEY_SW[3]=0 at edge 10, RESET=1 at edge 13 for one cycle -> no pulse before reset; press accepted after edge 19 (fresh count from edge 14).
REQ-033 Key held 1000 cycles -> single key_press pulse, key stays 1, no spurious pulse.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared FSM state type and default debounce length
package key_debounce_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_CHK, PRESSED, REL_CHK} deb_state_t;
  localparam int DEB_CYCLES_DEF = 1_000_000;
endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: synchronizer, debounce FSM and stability counter for one active-low key
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_sw,
  output logic key,
  output logic key_press,
  output logic key_release
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);
  logic [1:0] sync;
  logic lvl, key_n, press_n, release_n;
  deb_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  assign lvl = ~sync[1];
  always_ff @(posedge clk) begin
    if (rst) begin
      sync        <= 2'b11;
      state       <= IDLE;
      cnt         <= '0;
      key         <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      sync        <= {sync[0], key_sw};
      state       <= state_n;
      cnt         <= cnt_n;
      key         <= key_n;
      key_press   <= press_n;
      key_release <= release_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        state_n = lvl ? PRESS_CHK : IDLE;
        cnt_n   = lvl ? CW'(1) : '0;
      end
      PRESS_CHK: begin
        state_n = !lvl ? IDLE : (cnt == LAST) ? PRESSED : PRESS_CHK;
        cnt_n   = (!lvl || cnt == LAST) ? '0 : cnt + CW'(1);
      end
      PRESSED: begin
        state_n = lvl ? PRESSED : REL_CHK;
        cnt_n   = lvl ? '0 : CW'(1);
      end
      REL_CHK: begin
        state_n = lvl ? PRESSED : (cnt == LAST) ? IDLE : REL_CHK;
        cnt_n   = (lvl || cnt == LAST) ? '0 : cnt + CW'(1);
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end
  // outputs are computed from the next state so they register alongside it
  always_comb begin
    key_n     = (state_n == PRESSED) || (state_n == REL_CHK);
    press_n   = (state == PRESS_CHK) && (state_n == PRESSED);
    release_n = (state == REL_CHK) && (state_n == IDLE);
  end
endmodule

// File: rtl/key_debounce.sv
// key_debounce: N_KEYS independent debounced keys with press/release pulses
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int N_KEYS     = 4,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [N_KEYS-1:0] KEY_SW,
  output logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);
  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_ch (
      .clk        (CLK),
      .rst        (RESET),
      .key_sw     (KEY_SW[i]),
      .key        (key[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i])
    );
  end
endmodule
